// File: rtl/alu_pipe_cc.sv
// Registered Y86 OPq unit (ADD/SUB/AND/XOR) with a one-deep valid/ready output stage,
// Y86 condition-code register and a wrapping count of consumed results.
module alu_pipe_cc #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of,
  output logic [CNT_W-1:0] op_count
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] res;
  logic             res_of;
  logic             res_err;
  logic             accept;
  logic             pop;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // Y86 operand order: subq computes valB - valA
  always_comb begin
    res     = '0;
    res_of  = 1'b0;
    res_err = 1'b0;
    case (ifun)
      4'd0: begin
        res    = b + a;
        res_of = (a[MSB] == b[MSB]) && (res[MSB] != b[MSB]);
      end
      4'd1: begin
        res    = b - a;
        res_of = (a[MSB] != b[MSB]) && (res[MSB] != b[MSB]);
      end
      4'd2: res = a & b;
      4'd3: res = a ^ b;
      default: res_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= res;
      out_err   <= res_err;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end

  // Illegal functions never disturb the flags, even with set_cc asserted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_zf <= 1'b1;
      cc_sf <= 1'b0;
      cc_of <= 1'b0;
    end else if (accept && set_cc && !res_err) begin
      cc_zf <= (res == '0);
      cc_sf <= res[MSB];
      cc_of <= res_of;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (pop) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_pipe_cc.sv
// Directed bench for alu_pipe_cc: table of single-cycle vectors streamed back-to-back,
// then hand sequences for backpressure, async reset and counter wrap (CNT_W=2).
module tb_alu_pipe_cc;

  localparam int WIDTH = 64;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ifun;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             set_cc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
  logic             cc_zf;
  logic             cc_sf;
  logic             cc_of;
  logic [CNT_W-1:0] op_count;

  int checks   = 0;
  int failures = 0;

  alu_pipe_cc #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ifun      (ifun),
    .a         (a),
    .b         (b),
    .set_cc    (set_cc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .cc_zf     (cc_zf),
    .cc_sf     (cc_sf),
    .cc_of     (cc_of),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  ifun;
    logic [63:0] a;
    logic [63:0] b;
    logic        set_cc;
    logic [63:0] exp_data;
    logic        exp_err;
    logic        exp_zf;
    logic        exp_sf;
    logic        exp_of;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ifun      = 4'd0;
    a         = '0;
    b         = '0;
    set_cc    = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic drive(input logic [3:0] f, input logic [63:0] va, input logic [63:0] vb,
                       input logic sc);
    in_valid = 1'b1;
    ifun     = f;
    a        = va;
    b        = vb;
    set_cc   = sc;
  endtask

  initial begin
    //              ifun   a                      b                      cc  data                   err zf sf of
    vecs[0]  = '{4'd0,  64'd5,                 -64'sd5,               1, 64'd0,                 0, 1, 0, 0};
    vecs[1]  = '{4'd1,  64'd1,                 64'h8000_0000_0000_0000, 1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 0, 1};
    vecs[2]  = '{4'd2,  64'h3FF,               64'h368,               1, 64'h368,               0, 0, 0, 0};
    vecs[3]  = '{4'd3,  64'h3FB,               64'h3F9,               1, 64'h002,               0, 0, 0, 0};
    vecs[4]  = '{4'd0,  64'd2,                 -64'sd7,               1, 64'hFFFF_FFFF_FFFF_FFFB, 0, 0, 1, 0};
    vecs[5]  = '{4'd7,  64'd1,                 64'd2,                 1, 64'd0,                 1, 0, 1, 0};
    vecs[6]  = '{4'd3,  64'hF0,                64'hF0,                0, 64'd0,                 0, 0, 1, 0};
    vecs[7]  = '{4'd0,  64'h7FFF_FFFF_FFFF_FFFF, 64'd1,               1, 64'h8000_0000_0000_0000, 0, 0, 1, 1};
    vecs[8]  = '{4'd1,  64'd5,                 64'd5,                 1, 64'd0,                 0, 1, 0, 0};
    vecs[9]  = '{4'd15, 64'd9,                 64'd4,                 1, 64'd0,                 1, 1, 0, 0};
    vecs[10] = '{4'd1,  64'h8000_0000_0000_0000, 64'd0,               1, 64'h8000_0000_0000_0000, 0, 0, 1, 1};

    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_err", out_err, 0);
    check("rst_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
    check("rst_op_count", op_count, 0);
    check("rst_in_ready", in_ready, 1);

    // Streamed vectors, one per cycle, consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].ifun, vecs[i].a, vecs[i].b, vecs[i].set_cc);
      check($sformatf("v%0d_in_ready", i), in_ready, 1);
      step();
      check($sformatf("v%0d_out_valid", i), out_valid, 1);
      check($sformatf("v%0d_out_data", i), out_data, vecs[i].exp_data);
      check($sformatf("v%0d_out_err", i), out_err, vecs[i].exp_err);
      check($sformatf("v%0d_cc", i), {cc_zf, cc_sf, cc_of},
            {vecs[i].exp_zf, vecs[i].exp_sf, vecs[i].exp_of});
      check($sformatf("v%0d_op_count", i), op_count, i % 4);
    end
    in_valid = 1'b0;
    step();
    check("drain_out_valid", out_valid, 0);
    check("drain_out_data_hold", out_data, 64'h8000_0000_0000_0000);
    check("drain_op_count", op_count, NVEC % 4);

    // Backpressure: ADD 2+3 held for 3 cycles, second op (10-3) waits
    do_reset();
    out_ready = 1'b0;
    drive(4'd0, 64'd2, 64'd3, 1'b1);
    step();
    drive(4'd1, 64'd3, 64'd10, 1'b1);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp%0d_out_valid", c), out_valid, 1);
      check($sformatf("bp%0d_out_data", c), out_data, 5);
      check($sformatf("bp%0d_in_ready", c), in_ready, 0);
      step();
    end
    check("bp_op_count_stalled", op_count, 0);
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp_second_valid", out_valid, 1);
    check("bp_second_data", out_data, 7);
    check("bp_op_count1", op_count, 1);
    step();
    check("bp_empty_valid", out_valid, 0);
    check("bp_hold_data", out_data, 7);
    check("bp_op_count2", op_count, 2);

    // Async reset while a result is held under backpressure
    do_reset();
    out_ready = 1'b1;
    drive(4'd0, 64'd1, 64'd2, 1'b0);
    step();
    drive(4'd0, 64'd1, -64'sd3, 1'b1);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("ar_pre_valid", out_valid, 1);
    check("ar_pre_sf", cc_sf, 1);
    check("ar_pre_op_count", op_count, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_out_data", out_data, 0);
    check("ar_out_err", out_err, 0);
    check("ar_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
    check("ar_op_count", op_count, 0);
    step();
    rst_n = 1'b1;
    step();
    check("ar_after_valid", out_valid, 0);

    // Counter wrap: five pops on a 2-bit counter
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(4'd2, 64'(k), 64'hFF, 1'b0);
      step();
      if (k == 4) check("wrap_at4", op_count, 0);
    end
    in_valid = 1'b0;
    step();
    check("wrap_op_count", op_count, 1);
    check("wrap_last_data", out_data, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
